spram_arbiter: RTL and testbench
================================

Name: spram_arbiter

Overview:
- Round-robin arbiter sharing one single-port RAM bank (d1spram-style: wen/ren/waddr/raddr/wdata/rdata, fixed read latency) between NREQ requesters.
- Performs at most one RAM access per cycle, either a read or a write.
- Returns read data to the originating requester after RD_LAT cycles.
- Sits between the FIFO/buffer controllers and the shared RAM macro.

Parameters:
- NREQ, 4, number of requesters (1..16)
- WIDTH, 16, data width
- SIZE, 32, RAM depth in words; AW = $clog2(SIZE)
- RD_LAT, 1, RAM read latency in cycles (1..3)
- MAX_BURST, 4, max consecutive grants under lock (used only with SPRAM_ARB_LOCK_EN)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req  in  NREQ  per-requester access request
- req_we  in  NREQ  1 = write, 0 = read
- req_addr  in  NREQ*AW  packed addresses; requester i occupies [i*AW +: AW]
- req_wdata  in  NREQ*WIDTH  packed write data
- req_lock  in  NREQ  burst-lock request (present only with SPRAM_ARB_LOCK_EN)
- gnt  out  NREQ  one-hot grant, same cycle as the accepted request
- rsp_valid  out  NREQ  one-hot read-data valid
- rsp_rdata  out  WIDTH  read data, shared by all requesters
- mem_wen  out  1  RAM write enable
- mem_ren  out  1  RAM read enable
- mem_waddr  out  AW  RAM write address
- mem_raddr  out  AW  RAM read address
- mem_wdata  out  WIDTH  RAM write data
- mem_rdata  in  WIDTH  RAM read data, valid RD_LAT cycles after mem_ren

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: rr_ptr = 0; lock state cleared; gnt = 0 (no req); rsp_valid = 0; rsp_rdata = 0; all mem_* outputs = 0.
- Reset mid-operation: in-flight reads are discarded, and no rsp_valid is issued for them after reset.
- Handshake:
  - A requester holds req and its payload stable until it sees gnt.
  - A transfer happens in the cycle where req[i] & gnt[i] = 1.
  - gnt is combinational from req and registered state.
- Arbitration:
  - Search starts at rr_ptr and wraps mod NREQ; the first set req wins.
  - After a grant to requester i, rr_ptr <= (i+1) mod NREQ.
  - With no request, rr_ptr holds.
- Granted write: mem_wen = 1, mem_waddr = addr_i, mem_wdata = wdata_i, mem_ren = 0.
- Granted read: mem_ren = 1, mem_raddr = addr_i, mem_wen = 0.
- Non-granted mem_* fields are driven to 0.
- Never both mem_wen and mem_ren in the same cycle.
- Response pipeline:
  - Shift register of RD_LAT stages, each stage holding {valid, id}, with id width IDW = max(1, $clog2(NREQ)).
  - A stage is loaded on a granted read.
  - At the last stage: rsp_valid[id] = valid, rsp_rdata = mem_rdata when valid, else 0.
  - Back-to-back reads are supported every cycle; one response is produced per cycle.
- Read/write ordering:
  - A write granted in cycle t+1 to the same address as a read granted in cycle t does not affect that read's data. The RAM samples raddr in cycle t.
  - A read issued after a write to the same address returns the new data.
- NREQ = 1: gnt = req; rr_ptr is constant 0.
- No backpressure on responses: requesters always accept rsp_valid.

Optional Feature:
- Macro: SPRAM_ARB_LOCK_EN.
- Defined:
  - The req_lock port exists.
  - If the granted requester i has req_lock[i] = 1, it keeps priority for consecutive cycles while req[i] stays high, up to MAX_BURST grants.
  - Burst counter: 0..MAX_BURST.
  - When the counter reaches MAX_BURST, req[i] drops, or req_lock[i] drops, the lock releases and rr_ptr = i+1.
  - The next cycle is normal round-robin, with i at lowest priority.
  - Reset clears the lock and the counter.
- Undefined: no req_lock port and no counter; strict round-robin every cycle.

Decomposition:
- Package spram_arb_pkg holds:
  - function idw(n) = max(1, $clog2(n))
  - typedef rsp_tag_t {logic valid; logic [IDW-1:0] id} (parameterised via localparam in the module)
  - constant MAX_NREQ = 16
- Sub-module spram_rr_pick: combinational round-robin select. Inputs req and rr_ptr; outputs one-hot gnt and binary index.
- Top module holds rr_ptr, the lock counter, the mem mux and the response pipeline.

Test Plan:
- Reset then idle: rst high for 2 cycles, no req -> gnt = 0, rsp_valid = 0, mem_wen = mem_ren = 0, rr_ptr = 0.
- Fairness: req = 4'b1111 held for 8 cycles, all reads -> gnt sequence 0001, 0010, 0100, 1000 repeated twice. rsp_valid follows the same sequence, each RD_LAT = 1 cycle later.
- Write then read:
  - Requester 2 writes 0xBEEF to address 5.
  - Next cycle requester 0 reads address 5.
  - Expected: rsp_valid = 0001 with rsp_rdata = 0xBEEF one cycle later, and mem_wen/mem_ren never both high.
- Mixed contention, RD_LAT = 2: requester 1 reads address 3 (holding 0x1234) while requester 3 writes.
  - Requester 1 is granted first when rr_ptr = 0; requester 3 is granted in the following cycle.
  - Expected: rsp_valid = 0010 with data 0x1234 exactly 2 cycles after requester 1's grant.
- Reset mid-flight: a read is granted at t, rst is asserted at t+1 -> no rsp_valid at t+1 or after; rr_ptr = 0.
- Lock, with SPRAM_ARB_LOCK_EN and MAX_BURST = 4: requester 0 holds req and req_lock while requester 1 requests.
  - Expected: gnt = 0001 for 4 cycles, then 0010, then 0001.
  - Without the macro: gnt alternates 0001 / 0010.

Source files
------------

// File: rtl/spram_arb_pkg.sv
// rtl/spram_arb_pkg.sv - shared constants and helpers for the single-port RAM arbiter
//
// Purpose: holds the requester-count ceiling and the response-tag id width
// helper used by spram_arbiter and spram_rr_pick. The response tag struct
// itself is declared inside spram_arbiter because its id width depends on
// that module's NREQ parameter.
// Ports: none (package).

package spram_arb_pkg;

    localparam int MAX_NREQ = 16;

    // Width of a requester id: max(1, clog2(n)).
    function automatic int idw(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spram_rr_pick.sv
// rtl/spram_rr_pick.sv - combinational round-robin requester select
//
// Purpose: scans req_i starting at rr_ptr_i, wrapping modulo NREQ, and
// returns the first set requester as a one-hot grant and a binary index.
// Ports:
//   req_i     in  NREQ  request vector
//   rr_ptr_i  in  IDW   search start position (always < NREQ)
//   gnt_o     out NREQ  one-hot winner, zero when req_i is zero
//   idx_o     out IDW   binary winner index, zero when req_i is zero

module spram_rr_pick
    import spram_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = idw(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  rr_ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  idx_o
);

    logic found;
    int   pos;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        pos   = 0;
        for (int k = 0; k < NREQ; k++) begin
            pos = int'(rr_ptr_i) + k;
            if (pos >= NREQ) begin
                pos = pos - NREQ;
            end
            if (!found && req_i[pos]) begin
                found      = 1'b1;
                gnt_o[pos] = 1'b1;
                idx_o      = IDW'(pos);
            end
        end
    end

endmodule

// File: rtl/spram_arbiter.sv
// rtl/spram_arbiter.sv - round-robin arbiter sharing one single-port RAM between NREQ requesters
//
// Purpose: grants at most one RAM access (read or write) per cycle, rotating
// priority after every grant, and returns read data to the originating
// requester RD_LAT cycles later through a tag shift register.
// Optional build macro SPRAM_ARB_LOCK_EN adds req_lock: a granted requester
// holding req_lock keeps priority for up to MAX_BURST consecutive grants.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req/req_we/req_addr/req_wdata  per-requester request, direction, packed addr/data
//   req_lock                  per-requester burst lock (SPRAM_ARB_LOCK_EN only)
//   gnt                       one-hot grant, combinational, same cycle as transfer
//   rsp_valid/rsp_rdata       one-hot read-data valid and shared read data
//   mem_wen/mem_ren/mem_waddr/mem_raddr/mem_wdata/mem_rdata  RAM macro interface

module spram_arbiter
    import spram_arb_pkg::*;
#(
    parameter  int NREQ      = 4,
    parameter  int WIDTH     = 16,
    parameter  int SIZE      = 32,
    parameter  int RD_LAT    = 1,
    parameter  int MAX_BURST = 4,
    localparam int AW        = $clog2(SIZE),
    localparam int IDW       = idw(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       req_we,
    input  logic [NREQ*AW-1:0]    req_addr,
    input  logic [NREQ*WIDTH-1:0] req_wdata,
`ifdef SPRAM_ARB_LOCK_EN
    input  logic [NREQ-1:0]       req_lock,
`endif
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]      rsp_rdata,
    output logic                  mem_wen,
    output logic                  mem_ren,
    output logic [AW-1:0]         mem_waddr,
    output logic [AW-1:0]         mem_raddr,
    output logic [WIDTH-1:0]      mem_wdata,
    input  logic [WIDTH-1:0]      mem_rdata
);

    if (NREQ < 1 || NREQ > MAX_NREQ) begin : g_bad_nreq
        $error("spram_arbiter: NREQ out of range");
    end
    if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_lat
        $error("spram_arbiter: RD_LAT out of range");
    end
    if (MAX_BURST < 1) begin : g_bad_burst
        $error("spram_arbiter: MAX_BURST must be at least 1");
    end

    typedef struct packed {
        logic           valid;
        logic [IDW-1:0] id;
    } rsp_tag_t;

    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0] rr_gnt;
    logic [IDW-1:0]  rr_idx;
    logic            win_any;
    logic [IDW-1:0]  win_idx;
    rsp_tag_t        pipe_q [RD_LAT];

    spram_rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req_i    (req),
        .rr_ptr_i (rr_ptr_q),
        .gnt_o    (rr_gnt),
        .idx_o    (rr_idx)
    );

`ifdef SPRAM_ARB_LOCK_EN
    localparam int CW = $clog2(MAX_BURST + 1);

    logic           lock_q, lock_d;
    logic [IDW-1:0] lock_id_q, lock_id_d;
    logic [CW-1:0]  burst_q, burst_d, burst_n;
    logic           lock_hold;

    // The locked owner only overrides round-robin while it still asks with lock.
    assign lock_hold = lock_q && req[lock_id_q] && req_lock[lock_id_q];

    always_comb begin
        lock_d    = 1'b0;
        lock_id_d = lock_id_q;
        burst_d   = '0;
        burst_n   = '0;
        if (win_any && req_lock[win_idx]) begin
            burst_n = lock_hold ? burst_q + CW'(1) : CW'(1);
            // Reaching MAX_BURST releases; rr_ptr already points past the owner.
            if (burst_n < CW'(MAX_BURST)) begin
                lock_d    = 1'b1;
                lock_id_d = win_idx;
                burst_d   = burst_n;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q    <= 1'b0;
            lock_id_q <= '0;
            burst_q   <= '0;
        end else begin
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            burst_q   <= burst_d;
        end
    end
`endif

    // Winner selection; everything is held off while rst is high so no access
    // or grant escapes during reset.
    always_comb begin
        win_any = 1'b0;
        win_idx = '0;
        gnt     = '0;
        if (!rst) begin
            win_any = |req;
            win_idx = rr_idx;
            gnt     = rr_gnt;
`ifdef SPRAM_ARB_LOCK_EN
            if (lock_hold) begin
                win_idx         = lock_id_q;
                gnt             = '0;
                gnt[lock_id_q]  = 1'b1;
            end
`endif
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (win_any) begin
            rr_ptr_d = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + IDW'(1);
        end
    end

    always_comb begin
        mem_wen   = win_any && req_we[win_idx];
        mem_ren   = win_any && !req_we[win_idx];
        mem_waddr = '0;
        mem_raddr = '0;
        mem_wdata = '0;
        if (mem_wen) begin
            mem_waddr = req_addr[int'(win_idx)*AW +: AW];
            mem_wdata = req_wdata[int'(win_idx)*WIDTH +: WIDTH];
        end
        if (mem_ren) begin
            mem_raddr = req_addr[int'(win_idx)*AW +: AW];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                pipe_q[k] <= '0;
            end
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            pipe_q[0] <= '{valid: mem_ren, id: win_idx};
            for (int k = 1; k < RD_LAT; k++) begin
                pipe_q[k] <= pipe_q[k-1];
            end
        end
    end

    // rst also masks the last stage so a read already in its final stage
    // when reset arrives is never reported.
    always_comb begin
        rsp_valid = '0;
        rsp_rdata = '0;
        if (!rst && pipe_q[RD_LAT-1].valid) begin
            rsp_rdata = mem_rdata;
            for (int k = 0; k < NREQ; k++) begin
                rsp_valid[k] = (pipe_q[RD_LAT-1].id == IDW'(k));
            end
        end
    end

endmodule

// File: tb/tb_spram_arbiter.sv
// tb/tb_spram_arbiter.sv - self-checking bench for spram_arbiter against a queue-based reference model

module tb_spram_arbiter;

    localparam int NREQ      = 4;
    localparam int WIDTH     = 16;
    localparam int SIZE      = 32;
    localparam int RD_LAT    = 2;
    localparam int MAX_BURST = 4;
    localparam int AW        = 5;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ-1:0]       req_we = '0;
    logic [NREQ*AW-1:0]    req_addr = '0;
    logic [NREQ*WIDTH-1:0] req_wdata = '0;
`ifdef SPRAM_ARB_LOCK_EN
    logic [NREQ-1:0]       req_lock = '0;
    int                    lk_id = 0;
    int                    lk_cnt = 0;
`endif
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]      rsp_rdata;
    logic                  mem_wen, mem_ren;
    logic [AW-1:0]         mem_waddr, mem_raddr;
    logic [WIDTH-1:0]      mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    spram_arbiter #(
        .NREQ(NREQ), .WIDTH(WIDTH), .SIZE(SIZE), .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata),
`ifdef SPRAM_ARB_LOCK_EN
        .req_lock(req_lock),
`endif
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_waddr(mem_waddr),
        .mem_raddr(mem_raddr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // RAM macro model with RD_LAT read latency; idle slots carry junk data.
    logic             tb_clear = 1'b1;
    logic [WIDTH-1:0] ram   [SIZE];
    logic [WIDTH-1:0] rpipe [RD_LAT];

    always @(posedge clk) begin
        if (tb_clear) begin
            for (int k = 0; k < SIZE; k++) ram[k] <= '0;
        end else if (mem_wen) begin
            ram[mem_waddr] <= mem_wdata;
        end
        rpipe[0] <= mem_ren ? ram[mem_raddr] : WIDTH'($urandom);
        for (int k = 1; k < RD_LAT; k++) rpipe[k] <= rpipe[k-1];
    end
    assign mem_rdata = rpipe[RD_LAT-1];

    typedef struct {
        int               due;
        int               id;
        logic [WIDTH-1:0] data;
    } exp_t;

    exp_t             rq[$];
    logic [WIDTH-1:0] shadow [SIZE];
    int               m_ptr = 0;
    int               cyc = 0;
    int               n_chk = 0;
    int               n_fail = 0;
    int               g_w = -1;
    logic [31:0]      seen_gnt, seen_rv, seen_rd;
    int               exp_seq [6];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic set_rq(input int i, input int we, input int addr, input int data);
        req[i]                     = 1'b1;
        req_we[i]                  = we[0];
        req_addr[i*AW +: AW]       = addr[AW-1:0];
        req_wdata[i*WIDTH +: WIDTH] = data[WIDTH-1:0];
    endtask

    // One clock cycle: predict and check this cycle's outputs, then advance the model.
    task automatic step();
        int               w;
        bit               ew, er;
        int               ea;
        logic [WIDTH-1:0] ed;
        logic [31:0]      eg, erv, erd;
        #2;
        w = -1;
        if (!rst) begin
            for (int k = 0; k < NREQ; k++) begin
                if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
            end
`ifdef SPRAM_ARB_LOCK_EN
            if (lk_cnt > 0 && req[lk_id] && req_lock[lk_id]) w = lk_id;
`endif
        end
        eg = 0; ew = 0; er = 0; ea = 0; ed = '0;
        if (w >= 0) begin
            eg = 32'(1) << w;
            ew = req_we[w];
            er = !req_we[w];
            ea = int'(req_addr[w*AW +: AW]);
            ed = req_wdata[w*WIDTH +: WIDTH];
        end
        check_eq("gnt", 32'(gnt), eg);
        check_eq("mem_wen", 32'(mem_wen), 32'(ew));
        check_eq("mem_ren", 32'(mem_ren), 32'(er));
        check_eq("mem_waddr", 32'(mem_waddr), ew ? 32'(ea) : 32'(0));
        check_eq("mem_raddr", 32'(mem_raddr), er ? 32'(ea) : 32'(0));
        check_eq("mem_wdata", 32'(mem_wdata), ew ? 32'(ed) : 32'(0));
        check_eq("wen_ren_excl", 32'(mem_wen & mem_ren), 32'(0));
        erv = 0; erd = 0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            erv = 32'(1) << rq[0].id;
            erd = 32'(rq[0].data);
            void'(rq.pop_front());
        end
        if (rst) begin
            erv = 0; erd = 0;
        end
        check_eq("rsp_valid", 32'(rsp_valid), erv);
        check_eq("rsp_rdata", 32'(rsp_rdata), erd);
        seen_gnt = 32'(gnt); seen_rv = 32'(rsp_valid); seen_rd = 32'(rsp_rdata);
        g_w = w;
        if (rst) begin
            m_ptr = 0;
            rq.delete();
`ifdef SPRAM_ARB_LOCK_EN
            lk_cnt = 0;
`endif
        end else if (w >= 0) begin
            m_ptr = (w + 1) % NREQ;
            if (ew) shadow[ea] = ed;
            else    rq.push_back('{cyc + RD_LAT, w, shadow[ea]});
`ifdef SPRAM_ARB_LOCK_EN
            if (req_lock[w]) begin
                lk_cnt = (lk_cnt > 0 && lk_id == w) ? lk_cnt + 1 : 1;
                lk_id  = w;
                if (lk_cnt >= MAX_BURST) lk_cnt = 0;
            end else begin
                lk_cnt = 0;
            end
        end else begin
            lk_cnt = 0;
`endif
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        for (int k = 0; k < SIZE; k++) shadow[k] = '0;

        // Reset then idle
        rst = 1'b1;
        repeat (2) begin
            step();
            check_eq("reset_gnt", seen_gnt, 32'(0));
            check_eq("reset_rsp", seen_rv, 32'(0));
        end
        tb_clear = 1'b0;
        rst = 1'b0;

        // Fairness: all four requesters read continuously
        for (int i = 0; i < NREQ; i++) set_rq(i, 0, $urandom_range(0, SIZE-1), 0);
        for (int k = 0; k < 8; k++) begin
            step();
            check_eq("fair_seq", seen_gnt, 32'(1) << (k % 4));
            if (g_w >= 0) set_rq(g_w, 0, $urandom_range(0, SIZE-1), 0);
        end
        req = '0;

        // Write then read of the same word
        set_rq(2, 1, 5, 'hBEEF);
        step();
        check_eq("wr_gnt", seen_gnt, 32'b0100);
        req = '0;
        set_rq(0, 0, 5, 0);
        step();
        req = '0;
        repeat (RD_LAT) step();
        check_eq("wr_rd_valid", seen_rv, 32'b0001);
        check_eq("wr_rd_data", seen_rd, 32'hBEEF);

        // Mixed contention; the following write to the same word must not leak into the read
        set_rq(0, 1, 3, 'h1234);
        step();
        req = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_rq(1, 0, 3, 0);
        set_rq(3, 1, 3, 'h5555);
        step();
        check_eq("mix_first", seen_gnt, 32'b0010);
        req[1] = 1'b0;
        step();
        check_eq("mix_second", seen_gnt, 32'b1000);
        req = '0;
        step();
        check_eq("mix_rsp_valid", seen_rv, 32'b0010);
        check_eq("mix_rsp_data", seen_rd, 32'h1234);

        // Reset while a read is in flight
        set_rq(2, 0, 3, 0);
        step();
        req = '0;
        rst = 1'b1;
        step();
        check_eq("rst_flight_rsp", seen_rv, 32'(0));
        rst = 1'b0;
        repeat (3) begin
            step();
            check_eq("rst_flight_after", seen_rv, 32'(0));
        end
        set_rq(0, 0, 1, 0);
        set_rq(3, 0, 2, 0);
        step();
        check_eq("ptr_after_rst", seen_gnt, 32'b0001);
        req = '0;

        // Lock behaviour (or plain alternation without the lock build)
        rst = 1'b1;
        step();
        rst = 1'b0;
`ifdef SPRAM_ARB_LOCK_EN
        exp_seq = '{1, 1, 1, 1, 2, 1};
        req_lock[0] = 1'b1;
`else
        exp_seq = '{1, 2, 1, 2, 1, 2};
`endif
        set_rq(0, 0, 1, 0);
        set_rq(1, 0, 2, 0);
        for (int k = 0; k < 6; k++) begin
            step();
            check_eq("lock_seq", seen_gnt, 32'(exp_seq[k]));
        end
        req = '0;
`ifdef SPRAM_ARB_LOCK_EN
        req_lock = '0;
`endif

        // Randomized traffic with occasional resets
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 63) == 0);
            step();
            for (int i = 0; i < NREQ; i++) begin
                if (g_w == i) req[i] = 1'b0;
                if (!req[i] && $urandom_range(0, 1) == 1)
                    set_rq(i, $urandom_range(0, 1), $urandom_range(0, SIZE-1), $urandom);
            end
        end
        rst = 1'b0;
        req = '0;
        repeat (RD_LAT + 2) step();
        check_eq("drain_empty", 32'(rq.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
